tri_solve_block: RTL
====================

Name: tri_solve_block

Overview:
- Forward-substitution solver: reads the lower-triangular factor L produced by cholesky_block from an L RAM and solves L·y = b for y.
- Arithmetic is time-shared: products go through the shared array_mult port and divisions through the shared array_div port.
- Sits downstream of cholesky_block in the inverse path. Non-pipelined, one term at a time, fully deterministic latency.

Parameters:
N, 6, matrix dimension (rows/cols of L, length of b and y)
W, 32, data width, signed two's-complement fixed point
FRAC, 16, fractional bits (Q(W-FRAC).FRAC)
MULT_LAT, 4, enabled cycles from operand issue to valid shared-multiplier result
DIV_LAT, 8, enabled cycles from operand issue to valid shared-divider quotient

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  clock enable; all state, counters and shared units advance only when en=1
start  in  1  begin solve; sampled in IDLE only
b_in  in  N*W  right-hand side, element k at [k*W +: W]; sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when y_out valid
err  out  1  sticky: zero diagonal seen; cleared on next accepted start
y_out  out  N*W  solution vector, element k at [k*W +: W]; held until next start
l_addr  out  $clog2(N*N)  L RAM read address, row-major i*N+j; RAM read latency 1 enabled cycle
l_rdata  in  W  L RAM read data
mult_dataa  out  W  shared multiplier operand A
mult_datab  out  W  shared multiplier operand B
mult_result  in  2W  full signed product
dividend  out  2W  shared divider dividend
divisor  out  W  shared divider divisor
quotient  in  W  shared divider quotient

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0, y_out=0, l_addr=0, all operand outputs=0, i=j=0, acc=0.
- Registers: row i, column j, wait counter, signed acc (W), y[0..N-1].
- All transitions below require en=1. With en=0, everything holds.
- IDLE: on start, latch b_in, clear y and err, set i=0, j=0, acc=b[0], busy=1, go to RD.
- RD (1 cycle): l_addr=i*N+j; go to OP.
- OP (1 cycle): l_rdata is valid.
  - If j<i: mult_dataa=l_rdata, mult_datab=y[j].
  - If j==i: divisor=l_rdata, dividend=sign_ext(acc)<<FRAC.
  - Load the wait counter with MULT_LAT or DIV_LAT; go to WAIT.
  - Operands are held stable until the next OP.
- WAIT: counter decrements. On its last cycle (MULT_LAT or DIV_LAT cycles after OP), capture the result:
  - Off-diagonal term: acc = sat_W(acc - mult_result[FRAC+W-1:FRAC]), saturating to the W-bit signed range. Then j++ and go to RD.
  - Diagonal term: y[i]=quotient. If the latched divisor was 0, force y[i]=0 and set err=1. Then:
    - if i==N-1, go to DONE;
    - else i++, j=0, acc=b[i], go to RD.
- DONE (1 cycle): drive y_out from y, done=1, busy=0; go to IDLE.
- Latency from the accepted-start cycle to the done cycle, in enabled cycles: N(N-1)/2·(2+MULT_LAT) + N·(2+DIV_LAT) + 1. With the defaults this is 151.
- start while busy: ignored. start coincident with done: ignored; start is accepted only in IDLE.
- L upper triangle is never read (addresses with j>i are never issued).
- Reset mid-solve aborts immediately. y_out returns to 0; no done pulse.
- y_out changes only in DONE. err updates on the diagonal capture and is visible while busy.

Test Plan:
- N=2, Q16, L=[[0x20000,0],[0x10000,0x40000]], b=[0x40000,0xA0000], en=1:
  - y_out=[0x20000,0x20000], err=0, done exactly 27 cycles after start (MULT_LAT=4, DIV_LAT=8), busy high throughout.
  - Verifies the latency formula and that addresses 0, 2, 3 are read in order and address 1 is never read.
- N=6 defaults, L=identity·0x10000, b=k·0x10000: y_out=b; done at cycle 151.
- en toggled 1/0 every cycle on the N=2 case: same y_out; done after 54 total cycles; no state change on en=0 cycles.
- Zero diagonal L[1][1]=0 (N=2, otherwise as the first case): err=1 after the row-1 capture, y[1]=0, y[0]=0x20000; the next accepted start clears err.
- Saturation, N=2: L=[[0x10000,0],[0x7FFF0000,0x10000]], y0=0x7FFF0000, b1=0x80000000: acc saturates to 0x80000000 and y1=0x80000000.
- Reset asserted mid-WAIT of row 1: outputs return to 0 asynchronously, no done pulse; a fresh start completes normally. start pulsed while busy: ignored, and the in-progress result is unchanged.

Source files
------------

// File: rtl/tri_solve_block.sv
// Forward-substitution solver: solves L*y = b for y, where L is a lower-triangular
// factor held in an external RAM. One term at a time; products go through a shared
// multiplier and the diagonal divisions go through a shared divider.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                clock enable; nothing advances while low
//   start, b_in       begin a solve (accepted in idle only), right-hand side vector
//   busy, done, err   solve in progress, one-cycle completion pulse, sticky zero diagonal
//   y_out             solution vector, held until the next completed solve
//   l_addr, l_rdata   L RAM read port (row-major i*N+j, read latency one enabled cycle)
//   mult_dataa/datab  shared multiplier operands, mult_result full signed product
//   dividend/divisor  shared divider operands, quotient its result
module tri_solve_block #(
  parameter int unsigned N        = 6,
  parameter int unsigned W        = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 8,
  localparam int unsigned AW      = (N > 1) ? $clog2(N * N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [N*W-1:0]   b_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N*W-1:0]   y_out,
  output logic [AW-1:0]    l_addr,
  input  logic [W-1:0]     l_rdata,
  output logic [W-1:0]     mult_dataa,
  output logic [W-1:0]     mult_datab,
  input  logic [2*W-1:0]   mult_result,
  output logic [2*W-1:0]   dividend,
  output logic [W-1:0]     divisor,
  input  logic [W-1:0]     quotient
);

  localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW     = $clog2(MaxLat + 2);

  typedef enum logic [2:0] {StIdle, StRd, StOp, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     y_q [N];
  logic [W-1:0]     y_d [N];
  logic [W-1:0]     b_q [N];
  logic [W-1:0]     b_d [N];
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N*W-1:0]   y_out_q, y_out_d;
  logic [AW-1:0]    l_addr_q, l_addr_d;
  logic [W-1:0]     mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [2*W-1:0]   dividend_q, dividend_d;
  logic [W-1:0]     divisor_q, divisor_d;

  // Q-format product term: drop FRAC fraction bits, keep W bits.
  logic [W-1:0] term;
  logic         unused_mult_bits;
  assign term             = mult_result[FRAC+W-1:FRAC];
  assign unused_mult_bits = ^{mult_result[2*W-1:FRAC+W], mult_result[FRAC-1:0]};

  logic [IW-1:0] i_nxt, j_nxt;
  assign i_nxt = i_q + IW'(1);
  assign j_nxt = j_q + IW'(1);

  function automatic logic [AW-1:0] rc_addr(input logic [IW-1:0] r, input logic [IW-1:0] c);
    logic [31:0] t;
    t = 32'(r) * N + 32'(c);
    return t[AW-1:0];
  endfunction

  // a - b clamped to the W-bit signed range.
  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {a[W-1], a} - {b[W-1], b};
    if (d[W] != d[W-1]) begin
      return d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return d[W-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    y_d        = y_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    y_out_d    = y_out_q;
    l_addr_d   = l_addr_q;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int k = 0; k < N; k++) begin
            b_d[k] = b_in[k*W +: W];
            y_d[k] = '0;
          end
          err_d    = 1'b0;
          i_d      = '0;
          j_d      = '0;
          acc_d    = b_in[W-1:0];
          busy_d   = 1'b1;
          l_addr_d = '0;
          state_d  = StRd;
        end
      end
      // Address was registered on entry; the RAM samples it at the end of this cycle.
      StRd: state_d = StOp;
      StOp: begin
        if (j_q < i_q) begin
          mult_a_d = l_rdata;
          mult_b_d = y_q[j_q];
          cnt_d    = CW'(MULT_LAT);
        end else begin
          divisor_d  = l_rdata;
          dividend_d = {{W{acc_q[W-1]}}, acc_q} << FRAC;
          cnt_d      = CW'(DIV_LAT);
        end
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          if (j_q < i_q) begin
            acc_d    = sat_sub(acc_q, term);
            j_d      = j_nxt;
            l_addr_d = rc_addr(i_q, j_nxt);
            state_d  = StRd;
          end else begin
            // A zero pivot yields an undefined quotient; report it and use 0.
            if (divisor_q == '0) begin
              y_d[i_q] = '0;
              err_d    = 1'b1;
            end else begin
              y_d[i_q] = quotient;
            end
            if (i_q == IW'(N - 1)) begin
              for (int k = 0; k < N; k++) y_out_d[k*W +: W] = y_d[k];
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StDone;
            end else begin
              i_d      = i_nxt;
              j_d      = '0;
              acc_d    = b_q[i_nxt];
              l_addr_d = rc_addr(i_nxt, '0);
              state_d  = StRd;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      for (int k = 0; k < N; k++) begin
        y_q[k] <= '0;
        b_q[k] <= '0;
      end
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      y_out_q    <= '0;
      l_addr_q   <= '0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (en) begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      y_out_q    <= y_out_d;
      l_addr_q   <= l_addr_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign y_out      = y_out_q;
  assign l_addr     = l_addr_q;
  assign mult_dataa = mult_a_q;
  assign mult_datab = mult_b_q;
  assign dividend   = dividend_q;
  assign divisor    = divisor_q;

endmodule
